// File: rtl/note_seq_datapath.sv
// Note sequencer datapath: records {octave, note} pairs into a small slot memory,
// plays them back on demand and mirrors every slot change onto a VGA grid via draw requests.
module note_seq_datapath #(
    parameter int ADDR_W = 4,
    parameter int COLS   = 4,
    parameter int CELL_W = 36,
    parameter int CELL_H = 12,
    parameter int GAP    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        note_data,
    input  logic [1:0]        octave_data,
    input  logic              ld_note,
    input  logic              ld_play,
    input  logic              next_note_en,
    input  logic              loop_en,
    input  logic              clear,
    output logic [3:0]        note_out,
    output logic [1:0]        octave_out,
    output logic              note_valid,
    output logic              play_active,
    output logic              busy,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [7:0]        x_out,
    output logic [6:0]        y_out,
    output logic [2:0]        colour,
    output logic              draw_req,
    input  logic              draw_ack
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    localparam logic [2:0] COL_NOTE  = 3'b100;
    localparam logic [2:0] COL_PLAY  = 3'b110;
    localparam logic [2:0] COL_BLANK = 3'b000;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        CLEAR
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [3:0]        note_out_q, note_out_d;
    logic [1:0]        octave_out_q, octave_out_d;
    logic              note_valid_q, note_valid_d;
    logic              load_pend_q, load_pend_d;
    logic              clear_pend_q, clear_pend_d;
    logic              draw_req_q, draw_req_d;
    logic [7:0]        x_q, x_d;
    logic [6:0]        y_q, y_d;
    logic [2:0]        colour_q, colour_d;

    logic [5:0]        mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [5:0]        mem_wdata;
    logic [5:0]        rd_word;

    logic              draw_done;
    logic              enter_clear;
    logic              set_pend;
    logic              play_go;
    logic              note_go;
    logic              next_go;
    logic              last_rd;
    logic              last_clr;

    logic              draw_new;
    logic [ADDR_W-1:0] draw_slot;
    logic [2:0]        draw_colour;

    function automatic logic [7:0] slot_x(input logic [ADDR_W-1:0] slot);
        int col;
        col = int'(slot) % COLS;
        return 8'(GAP + col * (CELL_W + GAP));
    endfunction

    function automatic logic [6:0] slot_y(input logic [ADDR_W-1:0] slot);
        int row;
        row = int'(slot) / COLS;
        return 7'(GAP + row * (CELL_H + GAP));
    endfunction

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_word = mem[rd_ptr_q];

    // Request decode; a clear seen while a draw is outstanding is parked until that draw is acked.
    always_comb begin
        draw_done   = draw_req_q & draw_ack;
        enter_clear = (clear | clear_pend_q) & (~draw_req_q | draw_ack);
        set_pend    = clear & draw_req_q & ~draw_ack;
        play_go     = ~clear & ld_play & (count_q != '0) & ~busy;
        note_go     = ~clear & ~ld_play & ld_note & (state_q == IDLE) & ~busy;
        next_go     = ~clear & ~ld_play & ~ld_note & next_note_en & (state_q == PLAY) & ~busy;
        last_rd     = ({1'b0, rd_ptr_q} == (count_q - CNT_W'(1)));
        last_clr    = (clr_ptr_q == '1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (enter_clear) begin
            state_d = CLEAR;
        end else if (state_q == CLEAR) begin
            if (draw_done && last_clr) begin
                state_d = IDLE;
            end
        end else if (play_go) begin
            state_d = PLAY;
        end else if (next_go && last_rd && !loop_en) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        play_active = (state_q == PLAY);
        busy        = draw_req_q | (state_q == CLEAR);
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        clr_ptr_d    = clr_ptr_q;
        count_d      = count_q;
        note_out_d   = note_out_q;
        octave_out_d = octave_out_q;
        note_valid_d = note_valid_q;
        load_pend_d  = 1'b0;
        clear_pend_d = clear_pend_q;
        draw_req_d   = draw_req_q & ~draw_ack;
        x_d          = x_q;
        y_d          = y_q;
        colour_d     = colour_q;
        mem_we       = 1'b0;
        mem_waddr    = '0;
        mem_wdata    = '0;
        draw_new     = 1'b0;
        draw_slot    = '0;
        draw_colour  = COL_BLANK;

        // Playback data lands one cycle after the read pointer was loaded.
        if (load_pend_q) begin
            note_out_d   = rd_word[3:0];
            octave_out_d = rd_word[5:4];
            note_valid_d = 1'b1;
        end

        if (enter_clear) begin
            clear_pend_d = 1'b0;
        end else if (set_pend) begin
            clear_pend_d = 1'b1;
        end

        if (enter_clear) begin
            clr_ptr_d    = '0;
            note_valid_d = 1'b0;
            draw_req_d   = 1'b0;
        end else if (state_q == CLEAR) begin
            if (!draw_req_q) begin
                mem_we      = 1'b1;
                mem_waddr   = clr_ptr_q;
                mem_wdata   = '0;
                draw_new    = 1'b1;
                draw_slot   = clr_ptr_q;
                draw_colour = COL_BLANK;
            end else if (draw_done) begin
                if (last_clr) begin
                    count_d      = '0;
                    wr_ptr_d     = '0;
                    rd_ptr_d     = '0;
                    note_valid_d = 1'b0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
        end else if (play_go) begin
            rd_ptr_d    = '0;
            load_pend_d = 1'b1;
            draw_new    = 1'b1;
            draw_slot   = '0;
            draw_colour = COL_PLAY;
        end else if (note_go) begin
            mem_we      = 1'b1;
            mem_waddr   = wr_ptr_q;
            mem_wdata   = {octave_data, note_data};
            wr_ptr_d    = wr_ptr_q + 1'b1;
            if (count_q != CNT_W'(DEPTH)) begin
                count_d = count_q + 1'b1;
            end
            draw_new    = 1'b1;
            draw_slot   = wr_ptr_q;
            draw_colour = COL_NOTE;
        end else if (next_go) begin
            if (last_rd && !loop_en) begin
                note_valid_d = 1'b0;
            end else begin
                rd_ptr_d    = last_rd ? '0 : rd_ptr_q + 1'b1;
                load_pend_d = 1'b1;
                draw_new    = 1'b1;
                draw_slot   = rd_ptr_d;
                draw_colour = COL_PLAY;
            end
        end

        if (draw_new) begin
            draw_req_d = 1'b1;
            x_d        = slot_x(draw_slot);
            y_d        = slot_y(draw_slot);
            colour_d   = draw_colour;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            clr_ptr_q    <= '0;
            count_q      <= '0;
            note_out_q   <= '0;
            octave_out_q <= '0;
            note_valid_q <= 1'b0;
            load_pend_q  <= 1'b0;
            clear_pend_q <= 1'b0;
            draw_req_q   <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            clr_ptr_q    <= clr_ptr_d;
            count_q      <= count_d;
            note_out_q   <= note_out_d;
            octave_out_q <= octave_out_d;
            note_valid_q <= note_valid_d;
            load_pend_q  <= load_pend_d;
            clear_pend_q <= clear_pend_d;
            draw_req_q   <= draw_req_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
        end
    end

    assign note_out   = note_out_q;
    assign octave_out = octave_out_q;
    assign note_valid = note_valid_q;
    assign count      = count_q;
    assign wr_ptr     = wr_ptr_q;
    assign x_out      = x_q;
    assign y_out      = y_q;
    assign colour     = colour_q;
    assign draw_req   = draw_req_q;

endmodule

// File: doc/note_seq_datapath.md
NOTE_SEQ_DATAPATH -- requirements
Module: note_seq_datapath

Interface
REQ-001 Parameter ADDR_W, default 4, slot-address width; DEPTH = 2^ADDR_W note slots.
REQ-002 Parameter COLS, default 4, grid columns for on-screen slot layout.
REQ-003 Parameter CELL_W, default 36, cell width in pixels.
REQ-004 Parameter CELL_H, default 12, cell height in pixels.
REQ-005 Parameter GAP, default 4, pixel margin between and around cells.
REQ-006 Ports: clk in 1, sole clock; reset in 1, asynchronous active-low, clears all state when 0.
REQ-007 Ports: note_data in 4, note index; octave_data in 2, octave; ld_note in 1, store-note pulse.
REQ-008 Ports: ld_play in 1, start/restart playback pulse; next_note_en in 1, advance-playback pulse.
REQ-009 Ports: loop_en in 1, wrap playback to slot 0 at end; clear in 1, erase-all pulse.
REQ-010 Ports: note_out out 4, octave_out out 2, current playback note; note_valid out 1, note_out/octave_out meaningful.
REQ-011 Ports: play_active out 1; busy out 1; count out ADDR_W+1, stored notes; wr_ptr out ADDR_W.
REQ-012 Ports: x_out out 8, y_out out 7, colour out 3, draw_req out 1, draw_ack in 1 (VGA draw handshake).

Function
REQ-013 Storage SHALL be a DEPTH x 6 array of {octave, note}, synchronous read, one-cycle read latency.
REQ-014 FSM states SHALL be IDLE, PLAY, CLEAR; busy = draw_req OR state==CLEAR.
REQ-015 In IDLE with busy=0, ld_note SHALL write {octave_data, note_data} to slot wr_ptr, increment wr_ptr modulo DEPTH, and increment count saturating at DEPTH.
REQ-016 When full (count==DEPTH), ld_note SHALL overwrite slot wr_ptr (oldest-position wrap); count stays DEPTH.
REQ-017 Each accepted ld_note SHALL raise a draw of the written slot with colour 3'b100.
REQ-018 ld_play with count==0 SHALL be ignored; with count>0 and busy=0 it SHALL enter PLAY with rd_ptr=0 (from IDLE or PLAY).
REQ-019 In PLAY, note_out/octave_out SHALL equal slot rd_ptr one cycle after rd_ptr changes; note_valid asserts that cycle and stays high while in PLAY.
REQ-020 Each rd_ptr load SHALL raise a draw of slot rd_ptr with colour 3'b110.
REQ-021 In PLAY with busy=0, next_note_en SHALL increment rd_ptr; at rd_ptr==count-1 it SHALL reload 0 if loop_en=1, else return to IDLE with note_valid=0 and no draw.
REQ-022 ld_note SHALL be ignored in PLAY and CLEAR; ld_play and next_note_en SHALL be ignored when busy=1.
REQ-023 clear SHALL be accepted in any state regardless of busy, entering CLEAR after any pending draw_ack; it sweeps slots 0..DEPTH-1, writing 0 and drawing each with colour 3'b000, advancing one slot per draw_ack, then IDLE with count=0, wr_ptr=0, note_valid=0.
REQ-024 Same-cycle priority SHALL be clear > ld_play > ld_note > next_note_en; lower-priority requests that cycle are dropped.
REQ-025 Draw handshake: draw_req rises with x_out, y_out, colour stable; all three SHALL hold until draw_ack is sampled high while draw_req=1; draw_req falls the following cycle; at most one draw outstanding.
REQ-026 Coordinates for slot i: col=i mod COLS, row=i div COLS; x_out=GAP+col*(CELL_W+GAP), y_out=GAP+row*(CELL_H+GAP), truncated to 8 and 7 bits.
REQ-027 play_active SHALL equal (state==PLAY).

Reset
REQ-028 While reset=0: state IDLE, wr_ptr=0, rd_ptr=0, count=0, note_out=0, octave_out=0, note_valid=0, draw_req=0, x_out=0, y_out=0, colour=0, busy=0; array contents are not reset.
REQ-029 Reset asserted mid-PLAY or mid-CLEAR SHALL abort immediately to the REQ-028 values; the pending draw is discarded.

Verification
REQ-030 Record 3 notes (oct1/note2, oct0/note5, oct3/note11), acking each draw -> count=3, wr_ptr=3, draws at (4,4),(44,4),(84,4), colour 100.
REQ-031 ld_play, then next_note_en x3 with loop_en=0 -> note_out 2,5,11 each one cycle after rd_ptr load, then IDLE, note_valid=0, play_active=0.
REQ-032 Same with loop_en=1 -> fourth note is slot 0 (note 2, octave 1), play_active stays 1.
REQ-033 Write 17 notes (DEPTH=16) -> count=16, wr_ptr=1, slot 0 holds note 17; slot 15 draw at (124,52).
REQ-034 Hold draw_ack low 5 cycles after ld_note -> x/y/colour stable, subsequent ld_note and next_note_en ignored, busy=1.
REQ-035 clear and ld_play same cycle mid-PLAY -> CLEAR wins, 16 black draws at each slot, then count=0; later ld_play ignored.
